// File: rtl/uart_rx_frame_fifo.sv
// UART receive frame checker feeding a first-word-fall-through byte FIFO.
// Flags framing errors and overflow, with a saturating error counter.
module uart_rx_frame_fifo #(
  parameter int TAM_DATA   = 11,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3,
  parameter int ERR_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_busy,
  input  logic [TAM_DATA-1:0] rx_frame,
  input  logic                clr_status,
  output logic [7:0]          byte_data,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic                frame_err,
  output logic [ERR_W-1:0]    err_count,
  output logic                overflow,
  output logic [ADDR_W:0]     fifo_level
);

  typedef enum logic [1:0] {
    S_SYNC,
    S_IDLE,
    S_RECV,
    S_CHECK
  } state_t;

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(FIFO_DEPTH);

  state_t              state_q, state_d;
  logic [TAM_DATA-1:0] frame_q, frame_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_q, rd_q;
  logic [ADDR_W:0]   lvl_q;
  logic [ERR_W-1:0]  err_q;
  logic              ovf_q;

  logic good, check, full, push, pop, drop, bad;

  // FSM state and captured frame register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SYNC;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
    end
  end

  // Next-state: track one frame from busy rise to busy fall
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    unique case (state_q)
      S_SYNC:  if (!rx_busy) state_d = S_IDLE;
      S_IDLE:  if (rx_busy) state_d = S_RECV;
      S_RECV: begin
        if (!rx_busy) begin
          state_d = S_CHECK;
          frame_d = rx_frame;
        end
      end
      S_CHECK: state_d = S_IDLE;
      default: state_d = S_SYNC;
    endcase
  end

  // Frame check and FIFO push/pop qualification
  always_comb begin
    check = (state_q == S_CHECK);
    good  = !frame_q[0] && (frame_q[10:9] == 2'b11);
    full  = (lvl_q == FULL_LVL);
    pop   = byte_valid && byte_ready;
    push  = check && good && (!full || pop);
    drop  = check && good && full && !pop;
    bad   = check && !good;
  end

  // FIFO storage, pointers, level and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      err_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= frame_q[8:1];
        wr_q        <= wr_q + ADDR_W'(1);
      end
      if (pop) rd_q <= rd_q + ADDR_W'(1);
      if (push && !pop) lvl_q <= lvl_q + (ADDR_W+1)'(1);
      else if (pop && !push) lvl_q <= lvl_q - (ADDR_W+1)'(1);
      if (clr_status) begin
        ovf_q <= 1'b0;
        err_q <= '0;
      end else begin
        if (drop) ovf_q <= 1'b1;
        if (bad && (err_q != '1)) err_q <= err_q + ERR_W'(1);
      end
    end
  end

  // Output mapping
  always_comb begin
    byte_valid = (lvl_q != '0);
    byte_data  = mem_q[rd_q];
    frame_err  = bad;
    err_count  = err_q;
    overflow   = ovf_q;
    fifo_level = lvl_q;
  end

endmodule

// File: tb/tb_uart_rx_frame_fifo.sv
// Directed bench for uart_rx_frame_fifo: framing, FIFO order,
// overflow, error saturation, reset mid-frame and status clear.
module tb_uart_rx_frame_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_busy;
  logic [10:0] rx_frame;
  logic        clr_status;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        frame_err;
  logic [7:0]  err_count;
  logic        overflow;
  logic [3:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  logic ferr_chk, ferr_after, vld_chk;

  uart_rx_frame_fifo dut (
    .clk(clk), .reset(reset), .rx_busy(rx_busy), .rx_frame(rx_frame),
    .clr_status(clr_status), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready),
    .frame_err(frame_err), .err_count(err_count),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d,
                                     input logic st,
                                     input logic [1:0] sp);
    return {sp, d, st};
  endfunction

  task automatic send(input logic [7:0] d, input logic st,
                      input logic [1:0] sp, input logic pop,
                      input logic clr);
    rx_busy  = 1'b1;
    rx_frame = 11'($urandom);
    tick();
    rx_frame = mk(d, st, sp);
    rx_busy  = 1'b0;
    tick();
    ferr_chk   = frame_err;
    vld_chk    = byte_valid;
    byte_ready = pop;
    clr_status = clr;
    tick();
    byte_ready = 1'b0;
    clr_status = 1'b0;
    ferr_after = frame_err;
  endtask

  initial begin
    reset = 1'b1; rx_busy = 1'b0; rx_frame = '0;
    clr_status = 1'b0; byte_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", 32'(byte_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_data", 32'(byte_data), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    tick();

    send(8'h5A, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("t1_valid_early", 32'(vld_chk), 0);
    chk("t1_valid", 32'(byte_valid), 1);
    chk("t1_data", 32'(byte_data), 32'h5A);
    chk("t1_level", 32'(fifo_level), 1);
    chk("t1_ferr", 32'(ferr_chk), 0);

    send(8'h33, 1'b1, 2'b11, 1'b0, 1'b0);
    chk("t2_ferr", 32'(ferr_chk), 1);
    chk("t2_ferr_pulse", 32'(ferr_after), 0);
    chk("t2_err1", 32'(err_count), 1);
    chk("t2_level", 32'(fifo_level), 1);
    send(8'h44, 1'b0, 2'b01, 1'b0, 1'b0);
    chk("t2_stop_ferr", 32'(ferr_chk), 1);
    chk("t2_err2", 32'(err_count), 2);
    for (int i = 0; i < 258; i++) send(8'h00, 1'b1, 2'b00, 1'b0, 1'b0);
    chk("t2_sat", 32'(err_count), 32'hFF);
    chk("t2_level2", 32'(fifo_level), 1);

    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    chk("pop_level", 32'(fifo_level), 0);

    send(8'h66, 1'b1, 2'b11, 1'b0, 1'b1);
    chk("t6_ferr", 32'(ferr_chk), 1);
    chk("t6_err", 32'(err_count), 0);

    for (int i = 1; i <= 9; i++) send(8'(i), 1'b0, 2'b11, 1'b0, 1'b0);
    chk("t3_level", 32'(fifo_level), 8);
    chk("t3_ovf", 32'(overflow), 1);
    byte_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t3_drain", 32'(byte_data), 32'(i));
      tick();
    end
    byte_ready = 1'b0;
    chk("t3_empty", 32'(fifo_level), 0);
    chk("t3_valid", 32'(byte_valid), 0);

    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0, 2'b11, 1'b0, 1'b0);
    chk("t4_full", 32'(fifo_level), 8);
    send(8'h18, 1'b0, 2'b11, 1'b1, 1'b0);
    chk("t4_level", 32'(fifo_level), 8);
    chk("t4_ovf", 32'(overflow), 0);
    byte_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t4_drain", 32'(byte_data), 32'h10 + 32'(i));
      tick();
    end
    byte_ready = 1'b0;
    chk("t4_empty", 32'(byte_valid), 0);

    send(8'h77, 1'b1, 2'b11, 1'b0, 1'b0);
    send(8'h21, 1'b0, 2'b11, 1'b0, 1'b0);
    rx_busy = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_level", 32'(fifo_level), 0);
    chk("t5_err", 32'(err_count), 0);
    chk("t5_valid", 32'(byte_valid), 0);
    chk("t5_data", 32'(byte_data), 0);
    tick();
    rx_frame = mk(8'hEE, 1'b0, 2'b11);
    rx_busy = 1'b0;
    tick(); tick(); tick();
    chk("t5_nopush", 32'(fifo_level), 0);
    send(8'h3C, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("t5_next_valid", 32'(byte_valid), 1);
    chk("t5_next_data", 32'(byte_data), 32'h3C);
    chk("t5_next_level", 32'(fifo_level), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
